output_scheduler: RTL and testbench
===================================

Name: output_scheduler

Overview:
- Configuration controller for a bank of CHANNELS output_driver instances (one per injector/coil).
- Host writes new event parameters (start/end tooth, start/end counts, enable) into a shadow table, then issues a commit.
- The block applies each channel's new parameters only when that channel is between events, so a driver never sees its parameters change mid-event.
- Drives the drivers' configuration inputs and monitors their outputs to track each channel's event phase.

Parameters:
CHANNELS, 4, number of output_driver channels managed
timer_length, 24, width of start/end counts (matches output_driver)
WDOG_TEETH, 8, tooth edges allowed in ARMED without drv_out rising before forced return to IDLE

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
tooth_num  input  8  current tooth index from the decoder
tooth_edge  input  1  one-cycle tooth event strobe
sync_ok  input  1  decoder has crank sync; low forces all channels IDLE
wr_en  input  1  shadow table write strobe
wr_chan  input  $clog2(CHANNELS)  channel addressed by the write
wr_sel  input  2  field: 0 start_tooth, 1 end_tooth, 2 start_counts, 3 end_counts
wr_data  input  timer_length  write data; tooth fields use bits [7:0]
en_mask  input  CHANNELS  per-channel enable, sampled at commit
commit  input  1  one-cycle request to apply the shadow table
busy  output  1  a commit is still pending on at least one channel
drv_en  output  CHANNELS  per-channel en to the drivers
drv_start_tooth  output  8*CHANNELS  flattened; channel i at [8i+7:8i]
drv_end_tooth  output  8*CHANNELS  flattened, same layout
drv_start_counts  output  timer_length*CHANNELS  flattened
drv_end_counts  output  timer_length*CHANNELS  flattened
drv_out  input  CHANNELS  out of each output_driver, fed back

Behaviour:
- Reset: shadow, staging and active tables cleared to 0; drv_en=0; busy=0; all channel FSMs IDLE; pending bits 0; watchdogs 0.
- Write: the field is updated on the clk edge where wr_en=1. Writes to wr_chan >= CHANNELS are ignored.
- Commit at cycle t:
  - Shadow table and en_mask are copied to staging at edge t. A write in the same cycle is not included; it lands in shadow for the next commit.
  - All pending bits are set and busy=1 from t+1.
  - A commit while busy re-snaps staging and re-sets every pending bit. Channels already applied are applied again.
- Per-channel FSM, states IDLE, ARMED, ON:
  - IDLE->ARMED: drv_en[i] && tooth_edge && tooth_num==active start_tooth[i]. This is the same condition the driver uses to start its event.
  - ARMED->ON: drv_out[i] rises (registered previous value 0, current 1).
  - ON->IDLE: drv_out[i] falls.
  - ARMED->IDLE: the watchdog reaches WDOG_TEETH. The watchdog counts tooth_edge in ARMED and clears on leaving ARMED.
  - Any state->IDLE: sync_ok=0. The FSM stays IDLE while sync_ok=0.
- Apply:
  - Happens when pending[i] && state IDLE && the arm condition is false in that cycle.
  - Active entry i and drv_en[i] load from staging at that edge, and pending[i] clears.
  - If the arm condition is true in the same cycle, the event proceeds with the old values and the apply waits for the next IDLE.
  - Minimum latency is commit->outputs updated in 2 edges (stage at t, apply at t+1).
- busy deasserts on the edge after the last pending bit clears.
- Disabled channel (drv_en=0) stays IDLE, so a commit to it applies on the next cycle.
- start_tooth==end_tooth needs no special casing: the FSM follows drv_out only.
- A drv_out rise while IDLE (e.g. a stale event) is ignored and does not block the apply.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, ARMED=1, ON=2)
  - field select constants for wr_sel
  - default WDOG_TEETH
- One natural sub-module, output_channel_tracker: per-channel FSM, watchdog, edge detect on drv_out, and the apply/pending handshake. It is instantiated CHANNELS times in a generate loop. The top level holds the tables, the commit staging and busy.

Test Plan:
- Reset mid-event: assert reset_n=0 while ch0 is ON -> drv_en=0, busy=0, all drv_* buses 0 immediately.
- Idle apply: write ch1 start_tooth=5, end_tooth=7, start_counts=100, end_counts=200, en_mask=4'b0010, commit at t -> drv_* for ch1 take the new values at t+2; busy high at t+1 and low at t+3.
- Deferred apply:
  - Setup: ch0 active with start 3 / end 3; tooth 3 edge arms it; drv_out high 10 cycles.
  - Stimulus: commit start_tooth=9 while ON.
  - Required: drv_start_tooth[7:0] stays 3 until the cycle after drv_out falls, then becomes 9; busy stays high throughout.
- Collision: commit so that the apply cycle coincides with tooth_edge && tooth_num==active start_tooth -> the channel arms with the old values and the apply happens after the event ends.
- Watchdog: ch2 ARMED and drv_out held low for 8 tooth edges -> returns to IDLE and a pending commit applies on the next cycle.
- Sync loss and recommit:
  - sync_ok=0 during ARMED -> IDLE and the pending commit applies.
  - A second commit while busy with different data -> final active values equal the second commit's data on all channels.

Source files
------------

// File: rtl/output_scheduler_pkg.sv
// Shared types and constants for the output scheduler and its per-channel trackers.
// Holds the channel FSM encoding, the shadow-table field selects and the default watchdog length.
package output_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ON    = 2'd2
    } chan_state_t;

    localparam logic [1:0] SEL_START_TOOTH  = 2'd0;
    localparam logic [1:0] SEL_END_TOOTH    = 2'd1;
    localparam logic [1:0] SEL_START_COUNTS = 2'd2;
    localparam logic [1:0] SEL_END_COUNTS   = 2'd3;

    localparam int DEFAULT_WDOG_TEETH = 8;

endpackage

// File: rtl/output_channel_tracker.sv
// Tracks one driver's event phase and decides when its pending parameters may be applied; apply is combinational.
// No backpressure: an apply simply waits while the channel is mid-event or about to arm this cycle.
module output_channel_tracker
    import output_scheduler_pkg::*;
#(
    parameter int WDOG_TEETH = DEFAULT_WDOG_TEETH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync_ok,
    input  logic       tooth_edge,
    input  logic [7:0] tooth_num,
    input  logic [7:0] start_tooth,
    input  logic       en,
    input  logic       drv_out,
    input  logic       commit,
    output logic       apply,
    output logic       pending
);

    localparam int WW = $clog2(WDOG_TEETH + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TEETH - 1);

    chan_state_t   state, state_next;
    logic [WW-1:0] wdog, wdog_next;
    logic          drv_out_q;
    logic          arm, rise, fall;

    // Same start condition the driver itself uses, so both sides agree on when an event begins.
    assign arm   = en && tooth_edge && (tooth_num == start_tooth);
    assign rise  = drv_out && !drv_out_q;
    assign fall  = !drv_out && drv_out_q;
    assign apply = pending && (state == ST_IDLE) && !arm;

    always_comb begin
        state_next = state;
        wdog_next  = wdog;
        if (!sync_ok) begin
            state_next = ST_IDLE;
            wdog_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state_next = ST_ON;
                        wdog_next  = '0;
                    end else if (tooth_edge) begin
                        if (wdog == WDOG_LAST) begin
                            state_next = ST_IDLE;
                            wdog_next  = '0;
                        end else begin
                            wdog_next = wdog + 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (fall) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wdog      <= '0;
            drv_out_q <= 1'b0;
            pending   <= 1'b0;
        end else begin
            state     <= state_next;
            wdog      <= wdog_next;
            drv_out_q <= drv_out;
            // A fresh commit wins over an apply in the same cycle: staging has just changed.
            if (commit)     pending <= 1'b1;
            else if (apply) pending <= 1'b0;
        end
    end

endmodule

// File: rtl/output_scheduler.sv
// Shadow/staging/active parameter tables for CHANNELS output drivers; commit reaches the drivers 2 edges later at best.
// No backpressure: busy reports outstanding applies, a commit while busy re-snaps staging and restarts every channel.
module output_scheduler
    import output_scheduler_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int timer_length = 24,
    parameter int WDOG_TEETH   = DEFAULT_WDOG_TEETH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [7:0]                       tooth_num,
    input  logic                             tooth_edge,
    input  logic                             sync_ok,
    input  logic                             wr_en,
    input  logic [$clog2(CHANNELS)-1:0]      wr_chan,
    input  logic [1:0]                       wr_sel,
    input  logic [timer_length-1:0]          wr_data,
    input  logic [CHANNELS-1:0]              en_mask,
    input  logic                             commit,
    output logic                             busy,
    output logic [CHANNELS-1:0]              drv_en,
    output logic [8*CHANNELS-1:0]            drv_start_tooth,
    output logic [8*CHANNELS-1:0]            drv_end_tooth,
    output logic [timer_length*CHANNELS-1:0] drv_start_counts,
    output logic [timer_length*CHANNELS-1:0] drv_end_counts,
    input  logic [CHANNELS-1:0]              drv_out
);

    logic [7:0]              sh_start_tooth   [CHANNELS];
    logic [7:0]              sh_end_tooth     [CHANNELS];
    logic [timer_length-1:0] sh_start_counts  [CHANNELS];
    logic [timer_length-1:0] sh_end_counts    [CHANNELS];
    logic [7:0]              stg_start_tooth  [CHANNELS];
    logic [7:0]              stg_end_tooth    [CHANNELS];
    logic [timer_length-1:0] stg_start_counts [CHANNELS];
    logic [timer_length-1:0] stg_end_counts   [CHANNELS];
    logic [CHANNELS-1:0]     stg_en;
    logic [7:0]              act_start_tooth  [CHANNELS];
    logic [7:0]              act_end_tooth    [CHANNELS];
    logic [timer_length-1:0] act_start_counts [CHANNELS];
    logic [timer_length-1:0] act_end_counts   [CHANNELS];
    logic [CHANNELS-1:0]     apply;
    logic [CHANNELS-1:0]     pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sh_start_tooth[i]  <= '0;
                sh_end_tooth[i]    <= '0;
                sh_start_counts[i] <= '0;
                sh_end_counts[i]   <= '0;
            end
        end else if (wr_en && (int'(wr_chan) < CHANNELS)) begin
            case (wr_sel)
                SEL_START_TOOTH:  sh_start_tooth[wr_chan]  <= wr_data[7:0];
                SEL_END_TOOTH:    sh_end_tooth[wr_chan]    <= wr_data[7:0];
                SEL_START_COUNTS: sh_start_counts[wr_chan] <= wr_data;
                SEL_END_COUNTS:   sh_end_counts[wr_chan]   <= wr_data;
            endcase
        end
    end

    // Staging copies the pre-edge shadow, so a write alongside commit waits for the next commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                stg_start_tooth[i]  <= '0;
                stg_end_tooth[i]    <= '0;
                stg_start_counts[i] <= '0;
                stg_end_counts[i]   <= '0;
            end
            stg_en <= '0;
        end else if (commit) begin
            stg_start_tooth  <= sh_start_tooth;
            stg_end_tooth    <= sh_end_tooth;
            stg_start_counts <= sh_start_counts;
            stg_end_counts   <= sh_end_counts;
            stg_en           <= en_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_start_tooth[i]  <= '0;
                act_end_tooth[i]    <= '0;
                act_start_counts[i] <= '0;
                act_end_counts[i]   <= '0;
            end
            drv_en <= '0;
            busy   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (apply[i]) begin
                    act_start_tooth[i]  <= stg_start_tooth[i];
                    act_end_tooth[i]    <= stg_end_tooth[i];
                    act_start_counts[i] <= stg_start_counts[i];
                    act_end_counts[i]   <= stg_end_counts[i];
                    drv_en[i]           <= stg_en[i];
                end
            end
            busy <= commit || (|pending);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        output_channel_tracker #(
            .WDOG_TEETH (WDOG_TEETH)
        ) u_trk (
            .clk         (clk),
            .reset_n     (reset_n),
            .sync_ok     (sync_ok),
            .tooth_edge  (tooth_edge),
            .tooth_num   (tooth_num),
            .start_tooth (act_start_tooth[i]),
            .en          (drv_en[i]),
            .drv_out     (drv_out[i]),
            .commit      (commit),
            .apply       (apply[i]),
            .pending     (pending[i])
        );

        assign drv_start_tooth[8*i +: 8]                      = act_start_tooth[i];
        assign drv_end_tooth[8*i +: 8]                        = act_end_tooth[i];
        assign drv_start_counts[timer_length*i +: timer_length] = act_start_counts[i];
        assign drv_end_counts[timer_length*i +: timer_length]   = act_end_counts[i];
    end

endmodule

// File: tb/tb_output_scheduler.sv
// Bench for output_scheduler: directed scenarios plus random traffic, every cycle compared to a reference model.
module tb_output_scheduler;

    localparam int CH = 4;
    localparam int TL = 24;
    localparam int WD = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        tooth_num;
    logic              tooth_edge;
    logic              sync_ok;
    logic              wr_en;
    logic [1:0]        wr_chan;
    logic [1:0]        wr_sel;
    logic [TL-1:0]     wr_data;
    logic [CH-1:0]     en_mask;
    logic              commit;
    logic              busy;
    logic [CH-1:0]     drv_en;
    logic [8*CH-1:0]   drv_start_tooth;
    logic [8*CH-1:0]   drv_end_tooth;
    logic [TL*CH-1:0]  drv_start_counts;
    logic [TL*CH-1:0]  drv_end_counts;
    logic [CH-1:0]     drv_out;

    output_scheduler #(.CHANNELS(CH), .timer_length(TL), .WDOG_TEETH(WD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tooth_num        (tooth_num),
        .tooth_edge       (tooth_edge),
        .sync_ok          (sync_ok),
        .wr_en            (wr_en),
        .wr_chan          (wr_chan),
        .wr_sel           (wr_sel),
        .wr_data          (wr_data),
        .en_mask          (en_mask),
        .commit           (commit),
        .busy             (busy),
        .drv_en           (drv_en),
        .drv_start_tooth  (drv_start_tooth),
        .drv_end_tooth    (drv_end_tooth),
        .drv_start_counts (drv_start_counts),
        .drv_end_counts   (drv_end_counts),
        .drv_out          (drv_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tables held per field index, channel phase as 0 idle / 1 armed / 2 on.
    logic [31:0] m_sh  [CH][4];
    logic [31:0] m_st  [CH][4];
    logic [31:0] m_act [CH][4];
    bit          m_st_en  [CH];
    bit          m_act_en [CH];
    bit          m_pend   [CH];
    bit          m_prev   [CH];
    int          m_phase  [CH];
    int          m_teeth  [CH];
    bit          m_busy;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            for (int f = 0; f < 4; f++) begin
                m_sh[i][f] = 0; m_st[i][f] = 0; m_act[i][f] = 0;
            end
            m_st_en[i] = 0; m_act_en[i] = 0; m_pend[i] = 0;
            m_prev[i] = 0; m_phase[i] = 0; m_teeth[i] = 0;
        end
        m_busy = 0;
    endtask

    task automatic model_step();
        bit any_pend = 0;
        for (int i = 0; i < CH; i++) any_pend |= m_pend[i];
        for (int i = 0; i < CH; i++) begin
            bit arm, rose, fell, app;
            arm  = m_act_en[i] && tooth_edge && (tooth_num == m_act[i][0][7:0]);
            rose = drv_out[i] && !m_prev[i];
            fell = !drv_out[i] && m_prev[i];
            app  = m_pend[i] && (m_phase[i] == 0) && !arm;
            if (!sync_ok) begin
                m_phase[i] = 0; m_teeth[i] = 0;
            end else if (m_phase[i] == 0) begin
                if (arm) m_phase[i] = 1;
            end else if (m_phase[i] == 1) begin
                if (rose) begin
                    m_phase[i] = 2; m_teeth[i] = 0;
                end else if (tooth_edge) begin
                    m_teeth[i]++;
                    if (m_teeth[i] >= WD) begin m_phase[i] = 0; m_teeth[i] = 0; end
                end
            end else if (fell) begin
                m_phase[i] = 0;
            end
            if (app) begin
                for (int f = 0; f < 4; f++) m_act[i][f] = m_st[i][f];
                m_act_en[i] = m_st_en[i];
            end
            if (commit)   m_pend[i] = 1;
            else if (app) m_pend[i] = 0;
            m_prev[i] = drv_out[i];
        end
        m_busy = commit || any_pend;
        if (commit) begin
            for (int i = 0; i < CH; i++) begin
                for (int f = 0; f < 4; f++) m_st[i][f] = m_sh[i][f];
                m_st_en[i] = en_mask[i];
            end
        end
        if (wr_en && (int'(wr_chan) < CH))
            m_sh[wr_chan][wr_sel] = (wr_sel < 2) ? {24'd0, wr_data[7:0]} : {8'd0, wr_data};
    endtask

    task automatic check_outputs();
        logic [CH-1:0]    e_en;
        logic [8*CH-1:0]  e_stt, e_ent;
        logic [TL*CH-1:0] e_stc, e_enc;
        for (int i = 0; i < CH; i++) begin
            e_en[i]          = m_act_en[i];
            e_stt[8*i +: 8]  = m_act[i][0][7:0];
            e_ent[8*i +: 8]  = m_act[i][1][7:0];
            e_stc[TL*i +: TL] = m_act[i][2][TL-1:0];
            e_enc[TL*i +: TL] = m_act[i][3][TL-1:0];
        end
        check($sformatf("c%0d.drv_en", cyc),          128'(drv_en),           128'(e_en));
        check($sformatf("c%0d.start_tooth", cyc),     128'(drv_start_tooth),  128'(e_stt));
        check($sformatf("c%0d.end_tooth", cyc),       128'(drv_end_tooth),    128'(e_ent));
        check($sformatf("c%0d.start_counts", cyc),    128'(drv_start_counts), 128'(e_stc));
        check($sformatf("c%0d.end_counts", cyc),      128'(drv_end_counts),   128'(e_enc));
        check($sformatf("c%0d.busy", cyc),            128'(busy),             128'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic write_field(input int ch, input int sel, input logic [TL-1:0] data);
        wr_en = 1'b1; wr_chan = 2'(ch); wr_sel = 2'(sel); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input logic [CH-1:0] mask);
        en_mask = mask; commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic tooth(input int num);
        tooth_num = 8'(num); tooth_edge = 1'b1;
        tick();
        tooth_edge = 1'b0;
    endtask

    logic [TL-1:0] b_val [CH][4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench still running, expected to finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; tooth_num = '0; tooth_edge = 1'b0; sync_ok = 1'b1;
        wr_en = 1'b0; wr_chan = '0; wr_sel = '0; wr_data = '0;
        en_mask = '0; commit = 1'b0; drv_out = '0;
        model_reset();
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Idle apply on ch1.
        write_field(1, 0, 24'd5);
        write_field(1, 1, 24'd7);
        write_field(1, 2, 24'd100);
        write_field(1, 3, 24'd200);
        do_commit(4'b0010);
        check("idle_busy_t1", 128'(busy), 128'(1));
        check("idle_start_t1", 128'(drv_start_tooth[15:8]), 128'(0));
        tick();
        check("idle_start_t2", 128'(drv_start_tooth[15:8]), 128'(5));
        check("idle_end_t2", 128'(drv_end_tooth[15:8]), 128'(7));
        check("idle_scnt_t2", 128'(drv_start_counts[47:24]), 128'(100));
        check("idle_ecnt_t2", 128'(drv_end_counts[47:24]), 128'(200));
        check("idle_en_t2", 128'(drv_en), 128'(4'b0010));
        tick();
        check("idle_busy_t3", 128'(busy), 128'(0));

        // Deferred apply on ch0 while its event is on.
        write_field(0, 0, 24'd3);
        write_field(0, 1, 24'd3);
        do_commit(4'b0011);
        tick();
        tooth(3);
        drv_out[0] = 1'b1;
        tick();
        write_field(0, 0, 24'd9);
        do_commit(4'b0011);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("defer_hold%0d", k), 128'(drv_start_tooth[7:0]), 128'(3));
            check($sformatf("defer_busy%0d", k), 128'(busy), 128'(1));
        end
        drv_out[0] = 1'b0;
        tick();
        check("defer_fall", 128'(drv_start_tooth[7:0]), 128'(3));
        tick();
        check("defer_apply", 128'(drv_start_tooth[7:0]), 128'(9));

        // Collision: apply cycle coincides with the arming tooth.
        write_field(0, 0, 24'd4);
        do_commit(4'b0011);
        tooth(9);
        check("coll_old", 128'(drv_start_tooth[7:0]), 128'(9));
        drv_out[0] = 1'b1;
        tick(); tick(); tick();
        check("coll_on", 128'(drv_start_tooth[7:0]), 128'(9));
        drv_out[0] = 1'b0;
        tick();
        check("coll_fall", 128'(drv_start_tooth[7:0]), 128'(9));
        tick();
        check("coll_apply", 128'(drv_start_tooth[7:0]), 128'(4));

        // Watchdog on ch2.
        write_field(2, 0, 24'd6);
        do_commit(4'b0111);
        tick();
        tooth(6);
        write_field(2, 0, 24'd11);
        do_commit(4'b0111);
        for (int k = 1; k <= WD; k++) begin
            tooth(20);
            check($sformatf("wdog_hold%0d", k), 128'(drv_start_tooth[23:16]), 128'(6));
            if (k < WD) tick();
        end
        tick();
        check("wdog_apply", 128'(drv_start_tooth[23:16]), 128'(11));

        // Sync loss on ch3 while armed.
        write_field(3, 0, 24'd2);
        do_commit(4'b1111);
        tick();
        tooth(2);
        write_field(3, 0, 24'd13);
        do_commit(4'b1111);
        sync_ok = 1'b0;
        tick();
        check("sync_drop", 128'(drv_start_tooth[31:24]), 128'(2));
        sync_ok = 1'b1;
        tick();
        check("sync_apply", 128'(drv_start_tooth[31:24]), 128'(13));

        // Recommit while busy: ch0 held ON keeps the first commit pending.
        tooth(4);
        drv_out[0] = 1'b1;
        tick();
        for (int i = 0; i < CH; i++)
            for (int f = 0; f < 4; f++)
                write_field(i, f, (f < 2) ? 24'(50 + 4*i + f) : 24'($urandom));
        do_commit(4'b1111);
        for (int i = 0; i < CH; i++) begin
            b_val[i][0] = 24'(30 + i);
            b_val[i][1] = 24'(40 + i);
            b_val[i][2] = 24'($urandom);
            b_val[i][3] = 24'($urandom);
            for (int f = 0; f < 4; f++) write_field(i, f, b_val[i][f]);
        end
        check("recommit_busy_before", 128'(busy), 128'(1));
        do_commit(4'b1111);
        drv_out[0] = 1'b0;
        begin
            int n = 0;
            while (busy && n < 200) begin tick(); n++; end
        end
        check("recommit_busy_clear", 128'(busy), 128'(0));
        for (int i = 0; i < CH; i++) begin
            check($sformatf("recommit_st%0d", i), 128'(drv_start_tooth[8*i +: 8]), 128'(b_val[i][0][7:0]));
            check($sformatf("recommit_et%0d", i), 128'(drv_end_tooth[8*i +: 8]), 128'(b_val[i][1][7:0]));
            check($sformatf("recommit_sc%0d", i), 128'(drv_start_counts[TL*i +: TL]), 128'(b_val[i][2]));
            check($sformatf("recommit_ec%0d", i), 128'(drv_end_counts[TL*i +: TL]), 128'(b_val[i][3]));
        end

        // Reset while ch0 is mid-event.
        tooth(30);
        drv_out[0] = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_drv_en", 128'(drv_en), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_start_tooth", 128'(drv_start_tooth), 128'(0));
        check("rst_end_tooth", 128'(drv_end_tooth), 128'(0));
        check("rst_start_counts", 128'(drv_start_counts), 128'(0));
        check("rst_end_counts", 128'(drv_end_counts), 128'(0));
        model_reset();
        drv_out = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            tooth_edge = ($urandom_range(0, 2) == 0);
            tooth_num  = 8'($urandom_range(0, 15));
            sync_ok    = ($urandom_range(0, 39) != 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_chan    = 2'($urandom_range(0, 3));
            wr_sel     = 2'($urandom_range(0, 3));
            wr_data    = (wr_sel < 2) ? 24'($urandom_range(0, 15)) : 24'($urandom);
            commit     = ($urandom_range(0, 24) == 0);
            en_mask    = 4'($urandom);
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 5) == 0) drv_out[i] = ~drv_out[i];
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
